timer_digit_sequencer: RTL and testbench

TIMER_DIGIT_SEQUENCER -- requirements
Module: timer_digit_sequencer

---
 rtl/timer_pkg.sv | 59 +++++
 rtl/sub_divider.sv | 56 +++++
 rtl/timer_digit_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_timer_digit_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : timer_pkg
// Brief   : Shared FSM encoding, run-state codes and colour constants for the
//           timer digit sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package timer_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LATCH    = 3'd1;
  localparam logic [2:0] S_DIV_MIN  = 3'd2;
  localparam logic [2:0] S_DIV_TENS = 3'd3;
  localparam logic [2:0] S_ISSUE    = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic [1:0] RUN_COUNTING = 2'b00;
  localparam logic [1:0] RUN_STOPPED  = 2'b01;
  localparam logic [1:0] RUN_BLANK    = 2'b10;
  localparam logic [1:0] RUN_FINISHED = 2'b11;

  localparam logic [11:0] GREEN   = 12'h0F0;
  localparam logic [11:0] RED     = 12'hF00;
  localparam logic [11:0] BLACK   = 12'h000;
  localparam logic [11:0] CYAN    = 12'h0FF;
  localparam logic [11:0] MAGENTA = 12'hF0F;
  localparam logic [11:0] YELLOW  = 12'hFF0;

  // 99:59 is the largest displayable time
  localparam int TIME_LIMIT   = 6000;
  localparam int TIME_SAT     = 5999;
  localparam int SECS_PER_MIN = 60;

  typedef logic [1:0] digit_idx_t;

  function automatic logic [11:0] next_cycle_colour(input logic [11:0] cur);
    logic [11:0] nxt;
    case (cur)
      CYAN:    nxt = MAGENTA;
      MAGENTA: nxt = YELLOW;
      default: nxt = CYAN;
    endcase
    return nxt;
  endfunction

  function automatic logic [11:0] state_colour(input logic [1:0] run_code,
                                               input logic [11:0] cycle_rgb);
    logic [11:0] col;
    case (run_code)
      RUN_COUNTING: col = GREEN;
      RUN_STOPPED:  col = RED;
      RUN_BLANK:    col = BLACK;
      default:      col = cycle_rgb;
    endcase
    return col;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sub_divider.sv
`default_nettype none
// ============================================================================
// Module  : sub_divider
// Brief   : Sequential divider by a constant using one subtraction per cycle.
// Revision: 1.0 - initial release
// ============================================================================
module sub_divider #(
  parameter int WIDTH   = 8,
  parameter int DIVISOR = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] c_divisor = WIDTH'(DIVISOR);

  logic             r_run;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic             w_below;

  assign w_below = r_rem < c_divisor;

  // done is a single-cycle pulse: the run flag drops on the following edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
      r_quo <= '0;
      r_rem <= '0;
    end else if (start) begin
      r_run <= 1'b1;
      r_quo <= '0;
      r_rem <= dividend;
    end else if (r_run) begin
      if (w_below) begin
        r_run <= 1'b0;
      end else begin
        r_rem <= r_rem - c_divisor;
        r_quo <= r_quo + WIDTH'(1);
      end
    end
  end

  assign quotient  = r_quo;
  assign remainder = r_rem;
  assign busy      = r_run;
  assign done      = r_run & w_below;

endmodule
`default_nettype wire

// File: rtl/timer_digit_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : timer_digit_sequencer
// Brief   : Converts elapsed seconds to MM:SS and issues four coloured digits
//           to a drawer over a valid/ready handshake once per frame tick.
// Revision: 1.0 - initial release
// ============================================================================
module timer_digit_sequencer #(
  parameter int TIME_W       = 16,
  parameter int COORD_W      = 9,
  parameter int RGB_W        = 12,
  parameter int X_ORIGIN     = 120,
  parameter int DIGIT_PITCH  = 100,
  parameter int Y_ORIGIN     = 160,
  parameter int BLINK_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic [TIME_W-1:0]  time_s,
  input  logic [1:0]         run_state,
  output logic [3:0]         num,
  output logic [COORD_W-1:0] x0,
  output logic [COORD_W-1:0] y0,
  output logic [RGB_W-1:0]   rgb_draw,
  output logic               num_valid,
  input  logic               num_ready,
  output logic               busy,
  output logic               frame_done,
  output logic               overflow
);

  import timer_pkg::*;

  localparam int c_sec_w  = 13;
  localparam int c_min_w  = 7;
  localparam int c_tsec_w = 6;
  localparam int c_cnt_w  = $clog2(BLINK_FRAMES + 1);

  logic [2:0]         r_state;
  digit_idx_t         r_k;
  logic               r_pending;
  logic               r_overflow;
  logic [11:0]        r_rgb;
  logic [11:0]        r_cycle_rgb;
  logic [c_cnt_w-1:0] r_frame_cnt;

  logic               w_sat;
  logic [c_sec_w-1:0] w_time_sat;
  logic               w_issue;
  logic [3:0]         w_digit;

  logic                w_start_min;
  logic                w_start_tens;
  logic [c_sec_w-1:0]  w_min_quo;
  logic [c_sec_w-1:0]  w_min_rem;
  logic                w_min_busy;
  logic                w_min_done;
  logic [c_min_w-1:0]  w_tm_quo;
  logic [c_min_w-1:0]  w_tm_rem;
  logic                w_tm_busy;
  logic                w_tm_done;
  logic [c_tsec_w-1:0] w_ts_quo;
  logic [c_tsec_w-1:0] w_ts_rem;
  logic                w_ts_busy;
  logic                w_ts_done;
  logic                w_tens_done;
  logic                w_unused;

  always_comb begin
    w_sat      = 32'(time_s) >= TIME_LIMIT;
    w_time_sat = w_sat ? c_sec_w'(TIME_SAT) : c_sec_w'(time_s);
  end

  assign w_start_min  = (r_state == S_LATCH);
  assign w_start_tens = (r_state == S_DIV_MIN) && w_min_done;
  assign w_tens_done  = (!w_tm_busy || w_tm_done) && (!w_ts_busy || w_ts_done);

  sub_divider #(
    .WIDTH   (c_sec_w),
    .DIVISOR (SECS_PER_MIN)
  ) u_div_min (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (w_start_min),
    .dividend  (w_time_sat),
    .quotient  (w_min_quo),
    .remainder (w_min_rem),
    .busy      (w_min_busy),
    .done      (w_min_done)
  );

  sub_divider #(
    .WIDTH   (c_min_w),
    .DIVISOR (10)
  ) u_div_mins_tens (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (w_start_tens),
    .dividend  (c_min_w'(w_min_quo)),
    .quotient  (w_tm_quo),
    .remainder (w_tm_rem),
    .busy      (w_tm_busy),
    .done      (w_tm_done)
  );

  sub_divider #(
    .WIDTH   (c_tsec_w),
    .DIVISOR (10)
  ) u_div_secs_tens (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (w_start_tens),
    .dividend  (c_tsec_w'(w_min_rem)),
    .quotient  (w_ts_quo),
    .remainder (w_ts_rem),
    .busy      (w_ts_busy),
    .done      (w_ts_done)
  );

  // Quotient/remainder widths exceed the value ranges reached after saturation
  assign w_unused = ^{w_min_quo[c_sec_w-1:c_min_w], w_min_rem[c_sec_w-1:c_tsec_w],
                      w_tm_quo[c_min_w-1:4], w_tm_rem[c_min_w-1:4],
                      w_ts_quo[c_tsec_w-1:4], w_ts_rem[c_tsec_w-1:4], w_min_busy};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_overflow <= 1'b0;
      r_rgb      <= BLACK;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (frame_tick || r_pending) r_state <= S_LATCH;
        end
        S_LATCH: begin
          r_overflow <= w_sat;
          r_rgb      <= state_colour(run_state, r_cycle_rgb);
          r_k        <= '0;
          r_state    <= S_DIV_MIN;
        end
        S_DIV_MIN: begin
          if (w_min_done) r_state <= S_DIV_TENS;
        end
        S_DIV_TENS: begin
          if (w_tens_done) r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (num_ready) begin
            if (r_k == 2'd3) r_state <= S_DONE;
            else             r_k     <= r_k + 2'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // A tick arriving in LATCH is a fresh request and wins over the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
    end else if (frame_tick && (r_state != S_IDLE)) begin
      r_pending <= 1'b1;
    end else if (r_state == S_LATCH) begin
      r_pending <= 1'b0;
    end
  end

  // Colour steps on the first tick after BLINK_FRAMES ticks of the current one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_rgb <= CYAN;
      r_frame_cnt <= '0;
    end else if (run_state != RUN_FINISHED) begin
      r_cycle_rgb <= CYAN;
      r_frame_cnt <= '0;
    end else if (frame_tick) begin
      if (r_frame_cnt == c_cnt_w'(BLINK_FRAMES)) begin
        r_cycle_rgb <= next_cycle_colour(r_cycle_rgb);
        r_frame_cnt <= c_cnt_w'(1);
      end else begin
        r_frame_cnt <= r_frame_cnt + c_cnt_w'(1);
      end
    end
  end

  always_comb begin
    case (r_k)
      2'd0:    w_digit = w_tm_quo[3:0];
      2'd1:    w_digit = w_tm_rem[3:0];
      2'd2:    w_digit = w_ts_quo[3:0];
      default: w_digit = w_ts_rem[3:0];
    endcase
  end

  assign w_issue    = (r_state == S_ISSUE);
  assign num_valid  = w_issue;
  assign num        = w_issue ? w_digit : 4'd0;
  assign x0         = w_issue ? COORD_W'(X_ORIGIN + DIGIT_PITCH * int'(r_k)) : '0;
  assign y0         = w_issue ? COORD_W'(Y_ORIGIN) : '0;
  assign rgb_draw   = w_issue ? RGB_W'(r_rgb) : '0;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = (r_state == S_DONE);
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_timer_digit_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_timer_digit_sequencer
// Brief   : Scoreboard bench for timer_digit_sequencer with directed frames.
// Revision: 1.0 - initial release
// ============================================================================
module tb_timer_digit_sequencer;

  import timer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic [15:0] time_s = '0;
  logic [1:0]  run_state = RUN_COUNTING;
  logic        num_ready = 1'b1;
  logic [3:0]  num;
  logic [8:0]  x0;
  logic [8:0]  y0;
  logic [11:0] rgb_draw;
  logic        num_valid;
  logic        busy;
  logic        frame_done;
  logic        overflow;

  logic [24:0] exp_q[$];
  logic        ovf_q[$];
  logic [24:0] exp_d;
  logic [24:0] held_d;
  logic        held = 1'b0;
  logic        prev_done = 1'b0;
  logic        exp_ovf;

  int vectors = 0;
  int miscompares = 0;
  int frames_done = 0;
  int xfers = 0;
  int xfer_idx = 0;
  int stall_k = 0;
  int stall_len = 0;
  int stall_gen = 0;
  int seen_gen = 0;
  int stall_left = 0;
  int lat = 0;
  int snap = 0;
  int cyc = 0;

  int x_tab[4] = '{120, 220, 320, 420};

  always #5 clk = ~clk;

  timer_digit_sequencer #(
    .TIME_W       (16),
    .COORD_W      (9),
    .RGB_W        (12),
    .X_ORIGIN     (120),
    .DIGIT_PITCH  (100),
    .Y_ORIGIN     (160),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .time_s     (time_s),
    .run_state  (run_state),
    .num        (num),
    .x0         (x0),
    .y0         (y0),
    .rgb_draw   (rgb_draw),
    .num_valid  (num_valid),
    .num_ready  (num_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  task automatic push_frame(input int d0, input int d1, input int d2, input int d3,
                            input logic [11:0] rgb, input logic ovf);
    int d[4];
    d = '{d0, d1, d2, d3};
    for (int k = 0; k < 4; k++) exp_q.push_back({4'(d[k]), 9'(x_tab[k]), rgb});
    ovf_q.push_back(ovf);
  endtask

  task automatic pulse_tick();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
  endtask

  task automatic wait_frames(input int target, input string tag);
    int n = 0;
    while (frames_done < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (frames_done < target) begin
      miscompares++;
      $display("FAIL %s_timeout: frames_done=%0d, required %0d", tag, frames_done, target);
    end
  endtask

  task automatic do_frame(input int t, input logic [1:0] st, input int d0, input int d1,
                          input int d2, input int d3, input logic [11:0] rgb,
                          input logic ovf, input string tag);
    int target;
    time_s    = 16'(t);
    run_state = st;
    push_frame(d0, d1, d2, d3, rgb, ovf);
    target = frames_done + 1;
    pulse_tick();
    wait_frames(target, tag);
  endtask

  task automatic check_outputs_zero(input string tag);
    vectors++;
    if ({num, x0, y0, rgb_draw, num_valid, busy, frame_done, overflow} !== '0) begin
      miscompares++;
      $display("FAIL %s: num=%0d x0=%0d y0=%0d rgb=%h valid=%0b busy=%0b done=%0b ovf=%0b, required all 0",
               tag, num, x0, y0, rgb_draw, num_valid, busy, frame_done, overflow);
    end
  endtask

  task automatic monitor_step();
    if (!rst_n) begin
      held      = 1'b0;
      prev_done = 1'b0;
      xfer_idx  = 0;
      return;
    end
    if (held) begin
      vectors++;
      if (!num_valid || {num, x0, rgb_draw} !== held_d) begin
        miscompares++;
        $display("FAIL stall_hold: valid=%0b num=%0d x0=%0d rgb=%h, required valid=1 num=%0d x0=%0d rgb=%h",
                 num_valid, num, x0, rgb_draw, held_d[24:21], held_d[20:12], held_d[11:0]);
      end
    end
    held   = num_valid && !num_ready;
    held_d = {num, x0, rgb_draw};
    if (num_valid && num_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_digit: num=%0d x0=%0d rgb=%h, required no transfer", num, x0, rgb_draw);
      end else begin
        exp_d = exp_q.pop_front();
        if ({num, x0, rgb_draw} !== exp_d || y0 !== 9'd160) begin
          miscompares++;
          $display("FAIL digit_xfer: num=%0d x0=%0d y0=%0d rgb=%h, required num=%0d x0=%0d y0=160 rgb=%h",
                   num, x0, y0, rgb_draw, exp_d[24:21], exp_d[20:12], exp_d[11:0]);
        end
      end
      xfers++;
      xfer_idx = (xfer_idx + 1) % 4;
    end
    if (prev_done) begin
      vectors++;
      if (frame_done !== 1'b0) begin
        miscompares++;
        $display("FAIL frame_done_width: frame_done=%0b, required 0", frame_done);
      end
    end
    if (frame_done) begin
      frames_done++;
      vectors++;
      if (ovf_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_frame_done: frame %0d, required none", frames_done);
      end else begin
        exp_ovf = ovf_q.pop_front();
        if (overflow !== exp_ovf) begin
          miscompares++;
          $display("FAIL overflow: got %0b, required %0b", overflow, exp_ovf);
        end
      end
    end
    prev_done = frame_done;
  endtask

  task automatic drive_ready();
    if (!rst_n) begin
      stall_left = 0;
      num_ready  = 1'b1;
      return;
    end
    if (stall_gen != seen_gen) begin
      seen_gen   = stall_gen;
      stall_left = stall_len;
    end
    if (num_valid && xfer_idx == stall_k && stall_left > 0) begin
      num_ready = 1'b0;
      stall_left--;
    end else begin
      num_ready = 1'b1;
    end
  endtask

  initial begin
    fork
      forever begin @(negedge clk); monitor_step(); end
      forever begin @(posedge clk); #1; drive_ready(); end
    join_none

    repeat (3) @(negedge clk);
    check_outputs_zero("reset_state");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_frame(125, RUN_COUNTING, 0, 2, 0, 5, GREEN, 1'b0, "t125");

    // saturated value is the slowest division
    time_s    = 16'd7000;
    run_state = RUN_COUNTING;
    push_frame(9, 9, 5, 9, GREEN, 1'b1);
    snap = frames_done + 1;
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    lat = 1;
    while (!num_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    vectors++;
    if (lat > 112) begin
      miscompares++;
      $display("FAIL latency: got %0d cycles, required at most 112", lat);
    end
    wait_frames(snap, "t7000");

    do_frame(59,   RUN_COUNTING, 0, 0, 5, 9, GREEN, 1'b0, "t59");
    do_frame(6000, RUN_STOPPED,  9, 9, 5, 9, RED,   1'b1, "t6000");
    do_frame(5999, RUN_BLANK,    9, 9, 5, 9, BLACK, 1'b0, "t5999");
    do_frame(0,    RUN_COUNTING, 0, 0, 0, 0, GREEN, 1'b0, "t0");

    stall_k   = 1;
    stall_len = 5;
    stall_gen++;
    do_frame(3599, RUN_COUNTING, 5, 9, 5, 9, GREEN, 1'b0, "stall");

    run_state = RUN_FINISHED;
    @(negedge clk);
    do_frame(61, RUN_FINISHED, 0, 1, 0, 1, CYAN,    1'b0, "blink1");
    do_frame(61, RUN_FINISHED, 0, 1, 0, 1, CYAN,    1'b0, "blink2");
    do_frame(61, RUN_FINISHED, 0, 1, 0, 1, MAGENTA, 1'b0, "blink3");
    do_frame(61, RUN_FINISHED, 0, 1, 0, 1, MAGENTA, 1'b0, "blink4");
    do_frame(61, RUN_FINISHED, 0, 1, 0, 1, YELLOW,  1'b0, "blink5");
    do_frame(61, RUN_FINISHED, 0, 1, 0, 1, YELLOW,  1'b0, "blink6");

    // three extra ticks while busy collapse into one pending frame
    run_state = RUN_COUNTING;
    time_s    = 16'd1000;
    push_frame(1, 6, 4, 0, GREEN, 1'b0);
    push_frame(1, 6, 4, 0, GREEN, 1'b0);
    snap = frames_done + 2;
    pulse_tick();
    pulse_tick();
    pulse_tick();
    pulse_tick();
    wait_frames(snap, "pending");
    repeat (300) @(negedge clk);
    vectors++;
    if (frames_done != snap) begin
      miscompares++;
      $display("FAIL pending_count: frames_done=%0d, required %0d", frames_done, snap);
    end

    // reset while digit 2 is being offered
    time_s = 16'd3000;
    exp_q.push_back({4'd5, 9'd120, GREEN});
    exp_q.push_back({4'd0, 9'd220, GREEN});
    stall_k   = 2;
    stall_len = 100000;
    stall_gen++;
    pulse_tick();
    cyc = 0;
    while (!(num_valid && xfer_idx == 2) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (!(num_valid && xfer_idx == 2)) begin
      miscompares++;
      $display("FAIL reach_digit2: valid=%0b idx=%0d, required valid=1 idx=2", num_valid, xfer_idx);
    end
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    snap = xfers;
    repeat (200) @(negedge clk);
    vectors++;
    if (xfers != snap || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: transfers=%0d busy=%0b, required %0d and 0", xfers, busy, snap);
    end

    do_frame(754, RUN_COUNTING, 1, 2, 3, 4, GREEN, 1'b0, "t754");

    vectors++;
    if (exp_q.size() != 0 || ovf_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: %0d digits %0d frames outstanding, required 0", exp_q.size(), ovf_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
